// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU function codes,
// FSM state values and the EX-stage ALU function selection.
package mc_pkg;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'b100000;
  localparam opcode_t OP_LI    = 6'b111000;
  localparam opcode_t OP_LUI   = 6'b111001;
  localparam opcode_t OP_ADDI  = 6'b110000;
  localparam opcode_t OP_ANDI  = 6'b110010;
  localparam opcode_t OP_ORI   = 6'b110011;
  localparam opcode_t OP_B     = 6'b111111;
  localparam opcode_t OP_BEQ   = 6'b000000;
  localparam opcode_t OP_BNE   = 6'b000001;
  localparam opcode_t OP_LB    = 6'b000011;
  localparam opcode_t OP_SB    = 6'b000111;
  localparam opcode_t OP_LW    = 6'b001111;
  localparam opcode_t OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_DEC  = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_TRAP = 3'd7;

  // Branches compare by subtraction; address and immediate arithmetic use add.
  function automatic logic [3:0] alu_func_for(input opcode_t op, input logic [3:0] func);
    logic [3:0] f;
    case (op)
      OP_RTYPE:       f = func;
      OP_ANDI:        f = ALU_AND;
      OP_ORI:         f = ALU_OR;
      OP_BEQ, OP_BNE: f = ALU_SUB;
      default:        f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational opcode classifier; byte load/store are illegal when BYTE_OPS is 0.
module mc_decoder
  import mc_pkg::*;
#(
  parameter int BYTE_OPS = 1
) (
  input  logic [5:0] i_opcode,
  output logic       o_rtype,
  output logic       o_imm,
  output logic       o_branch,
  output logic       o_load,
  output logic       o_store,
  output logic       o_byte,
  output logic       o_lui,
  output logic       o_illegal
);

  // Opcode to class bits.
  always_comb begin
    o_rtype   = 1'b0;
    o_imm     = 1'b0;
    o_branch  = 1'b0;
    o_load    = 1'b0;
    o_store   = 1'b0;
    o_byte    = 1'b0;
    o_lui     = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: o_rtype = 1'b1;
      OP_LI, OP_ADDI, OP_ANDI, OP_ORI: o_imm = 1'b1;
      OP_LUI: begin
        o_imm = 1'b1;
        o_lui = 1'b1;
      end
      OP_B, OP_BEQ, OP_BNE: o_branch = 1'b1;
      OP_LW: begin
        o_imm  = 1'b1;
        o_load = 1'b1;
      end
      OP_SW: begin
        o_imm   = 1'b1;
        o_store = 1'b1;
      end
      OP_LB: begin
        if (BYTE_OPS != 0) begin
          o_imm  = 1'b1;
          o_load = 1'b1;
          o_byte = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_SB: begin
        if (BYTE_OPS != 0) begin
          o_imm   = 1'b1;
          o_store = 1'b1;
          o_byte  = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle IF/DEC/EX/MEM/WB controller with memory handshakes, a wait watchdog,
// a retired-instruction counter and a sticky trap state.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32,
  parameter int BYTE_OPS = 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               IR_LdEn,
  output logic               PC_sel,
  output logic               PC_LdEn,
  output logic               RF_WrEn,
  output logic               RF_WrData_sel,
  output logic               RF_B_sel,
  output logic               ALU_Bin_sel,
  output logic [3:0]         ALU_func,
  output logic               Mem_WrEn,
  output logic               lui,
  output logic               lb,
  output logic               sb,
  output logic               trap,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CW-1:0]    r_wait_cnt;
  logic [CNT_W-1:0] r_retired;

  logic [5:0] w_opcode;
  logic [3:0] w_func;
  logic       w_unused_bits;
  logic       w_rtype, w_imm, w_branch, w_load, w_store, w_byte, w_lui, w_illegal;
  logic       w_ready;
  logic       w_timeout;
  logic       w_take;

  assign w_opcode      = Instr[INSTR_W-1 -: 6];
  assign w_func        = Instr[3:0];
  assign w_unused_bits = ^Instr[INSTR_W-7:4];

  mc_decoder #(
    .BYTE_OPS (BYTE_OPS)
  ) u_decoder (
    .i_opcode  (w_opcode),
    .o_rtype   (w_rtype),
    .o_imm     (w_imm),
    .o_branch  (w_branch),
    .o_load    (w_load),
    .o_store   (w_store),
    .o_byte    (w_byte),
    .o_lui     (w_lui),
    .o_illegal (w_illegal)
  );

  // The watchdog only matters in IF and MEM; a ready in the final wait cycle beats the timeout.
  assign w_ready   = (r_state == ST_IF) ? imem_ready : dmem_ready;
  assign w_timeout = (r_wait_cnt == WAIT_LAST) && !w_ready;
  assign w_take    = (w_opcode == OP_B) | ((w_opcode == OP_BEQ) & Zero) |
                     ((w_opcode == OP_BNE) & ~Zero);

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt   = r_state;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    IR_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Mem_WrEn      = 1'b0;
    lui           = 1'b0;
    lb            = 1'b0;
    sb            = 1'b0;
    trap          = 1'b0;
    if (Reset) begin
      w_state_nxt = ST_IF;
    end else begin
      case (r_state)
        ST_IF: begin
          if (imem_ready) begin
            imem_req    = 1'b1;
            IR_LdEn     = 1'b1;
            w_state_nxt = ST_DEC;
          end else if (w_timeout) begin
            w_state_nxt = ST_TRAP;
          end else begin
            imem_req = 1'b1;
          end
        end
        ST_DEC: begin
          RF_B_sel    = ~w_rtype;
          w_state_nxt = w_illegal ? ST_TRAP : ST_EX;
        end
        ST_EX: begin
          RF_B_sel    = ~w_rtype;
          ALU_func    = alu_func_for(w_opcode, w_func);
          ALU_Bin_sel = w_imm;
          if (w_branch) begin
            PC_sel      = w_take;
            PC_LdEn     = 1'b1;
            w_state_nxt = ST_IF;
          end else if (w_load || w_store) begin
            w_state_nxt = ST_MEM;
          end else begin
            w_state_nxt = ST_WB;
          end
        end
        ST_MEM: begin
          // Address operands stay stable for the whole access.
          RF_B_sel    = ~w_rtype;
          ALU_func    = alu_func_for(w_opcode, w_func);
          ALU_Bin_sel = w_imm;
          lb          = w_byte & w_load;
          sb          = w_byte & w_store;
          Mem_WrEn    = w_store && (r_wait_cnt == {CW{1'b0}});
          if (dmem_ready) begin
            dmem_req = 1'b1;
            if (w_store) begin
              PC_LdEn     = 1'b1;
              w_state_nxt = ST_IF;
            end else begin
              w_state_nxt = ST_WB;
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_TRAP;
          end else begin
            dmem_req = 1'b1;
          end
        end
        ST_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = w_load;
          lui           = w_lui;
          lb            = w_byte & w_load;
          PC_LdEn       = 1'b1;
          w_state_nxt   = ST_IF;
        end
        ST_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          w_state_nxt = ST_TRAP;
        end
      endcase
    end
  end

  // State, watchdog and retire counters.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= ST_IF;
      r_wait_cnt <= {CW{1'b0}};
      r_retired  <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, PC_LdEn};
      if (w_state_nxt != r_state) begin
        r_wait_cnt <= {CW{1'b0}};
      end else if (!w_ready && (r_wait_cnt != WAIT_LAST)) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expectations (latency, handshake lengths,
// control pulses, retire count, traps) derived from the instruction rules.
module tb_multicycle_control;

  localparam int TO = 4;

  localparam logic [5:0] O_R    = 6'b100000;
  localparam logic [5:0] O_LI   = 6'b111000;
  localparam logic [5:0] O_LUI  = 6'b111001;
  localparam logic [5:0] O_ADDI = 6'b110000;
  localparam logic [5:0] O_ANDI = 6'b110010;
  localparam logic [5:0] O_ORI  = 6'b110011;
  localparam logic [5:0] O_B    = 6'b111111;
  localparam logic [5:0] O_BEQ  = 6'b000000;
  localparam logic [5:0] O_BNE  = 6'b000001;
  localparam logic [5:0] O_LB   = 6'b000011;
  localparam logic [5:0] O_SB   = 6'b000111;
  localparam logic [5:0] O_LW   = 6'b001111;
  localparam logic [5:0] O_SW   = 6'b011111;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;

  logic imem_req, dmem_req, IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic ALU_Bin_sel, Mem_WrEn, lui, lb, sb, trap;
  logic [3:0]  ALU_func;
  logic [2:0]  state;
  logic [31:0] retired;

  logic nb_imem_req, nb_dmem_req, nb_IR_LdEn, nb_PC_sel, nb_PC_LdEn, nb_RF_WrEn;
  logic nb_RF_WrData_sel, nb_RF_B_sel, nb_ALU_Bin_sel, nb_Mem_WrEn, nb_lui, nb_lb, nb_sb, nb_trap;
  logic [3:0]  nb_ALU_func;
  logic [2:0]  nb_state;
  logic [31:0] nb_retired;

  int n_tests = 0;
  int n_fail  = 0;
  int model_ret = 0;

  logic [5:0] legal_ops [13] = '{O_R, O_LI, O_LUI, O_ADDI, O_ANDI, O_ORI, O_B,
                                 O_BEQ, O_BNE, O_LB, O_SB, O_LW, O_SW};

  multicycle_control #(.INSTR_W(32), .TIMEOUT(TO), .CNT_W(32), .BYTE_OPS(1)) u_dut (
    .clk(clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IR_LdEn(IR_LdEn), .PC_sel(PC_sel),
    .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel),
    .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Mem_WrEn(Mem_WrEn), .lui(lui),
    .lb(lb), .sb(sb), .trap(trap), .state(state), .retired(retired)
  );

  multicycle_control #(.INSTR_W(32), .TIMEOUT(TO), .CNT_W(32), .BYTE_OPS(0)) u_dut_nb (
    .clk(clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(nb_imem_req), .dmem_req(nb_dmem_req), .IR_LdEn(nb_IR_LdEn), .PC_sel(nb_PC_sel),
    .PC_LdEn(nb_PC_LdEn), .RF_WrEn(nb_RF_WrEn), .RF_WrData_sel(nb_RF_WrData_sel),
    .RF_B_sel(nb_RF_B_sel), .ALU_Bin_sel(nb_ALU_Bin_sel), .ALU_func(nb_ALU_func),
    .Mem_WrEn(nb_Mem_WrEn), .lui(nb_lui), .lb(nb_lb), .sb(nb_sb), .trap(nb_trap),
    .state(nb_state), .retired(nb_retired)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends at a falling edge; leaves the DUTs in their first IF cycle.
  task automatic do_reset();
    Reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_trap", 32'(trap), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_pc_ld", 32'(PC_LdEn), 32'd0);
    check_eq("rst_nb_state", 32'(nb_state), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    model_ret = 0;
  endtask

  // Runs one instruction; memories answer after iw / dw wait cycles.
  task automatic run_instr(input logic [5:0] op, input logic [3:0] fn, input logic z,
                           input int iw, input int dw);
    int kind, cyc, icnt, dcnt, ireq, dreq, irld, pcld, rfwr, mwr, wr_cyc;
    int exp_cyc, exp_ireq, exp_dreq;
    logic done, seen_trap, psel, wsel, luif, rfb, bin, lbm, sbm, trap_out, busy_at_trap;
    logic [3:0] fsel, exp_func;
    logic is_mem, exp_trap, exp_take, exp_rfwr;
    case (op)
      O_R:                        kind = 0;
      O_LI, O_ADDI, O_ANDI, O_ORI: kind = 1;
      O_LUI:                      kind = 2;
      O_B, O_BEQ, O_BNE:          kind = 3;
      O_LW, O_LB:                 kind = 4;
      O_SW, O_SB:                 kind = 5;
      default:                    kind = 6;
    endcase
    case (op)
      O_R:          exp_func = fn;
      O_ANDI:       exp_func = 4'b0010;
      O_ORI:        exp_func = 4'b0011;
      O_BEQ, O_BNE: exp_func = 4'b0001;
      default:      exp_func = 4'b0000;
    endcase
    exp_take = (op == O_B) || (op == O_BEQ && z) || (op == O_BNE && !z);
    is_mem   = (kind == 4) || (kind == 5);
    exp_trap = (kind == 6) || (iw >= TO) || (is_mem && dw >= TO);
    exp_rfwr = !exp_trap && (kind == 0 || kind == 1 || kind == 2 || kind == 4);
    if (iw >= TO)              exp_cyc = TO + 1;
    else if (kind == 6)        exp_cyc = iw + 3;
    else if (is_mem && dw >= TO) exp_cyc = iw + TO + 4;
    else exp_cyc = iw + 3 + (is_mem ? dw + 1 : 0) + ((kind == 3 || kind == 5) ? 0 : 1);
    exp_ireq = (iw >= TO) ? TO - 1 : iw + 1;
    exp_dreq = (iw >= TO || !is_mem) ? 0 : ((dw >= TO) ? TO - 1 : dw + 1);

    {cyc, icnt, dcnt, ireq, dreq, irld, pcld, rfwr, mwr, wr_cyc} = '0;
    {done, seen_trap, psel, wsel, luif, rfb, bin, lbm, sbm, trap_out, busy_at_trap} = '0;
    fsel = 4'hx;
    Instr = {op, 22'($urandom), fn};
    Zero  = z;
    while (!done && cyc < 60) begin
      imem_ready = (state == 3'd0) && (icnt >= iw);
      dmem_ready = (state == 3'd3) && (dcnt >= dw);
      #1;
      cyc++;
      if (state == 3'd0) icnt++;
      if (state == 3'd3) begin
        dcnt++;
        lbm = lb;
        sbm = sb;
      end
      if (state == 3'd1) rfb = RF_B_sel;
      if (state == 3'd2) begin
        fsel = ALU_func;
        bin  = ALU_Bin_sel;
      end
      if (imem_req) ireq++;
      if (dmem_req) dreq++;
      if (IR_LdEn)  irld++;
      if (Mem_WrEn) mwr++;
      if (RF_WrEn) begin
        rfwr++;
        wsel   = RF_WrData_sel;
        luif   = lui;
        wr_cyc = cyc;
      end
      if (PC_LdEn) begin
        pcld++;
        psel = PC_sel;
        done = 1'b1;
      end
      if (state == 3'd7) begin
        seen_trap    = 1'b1;
        trap_out     = trap;
        busy_at_trap = imem_req | dmem_req | PC_LdEn | RF_WrEn | Mem_WrEn | IR_LdEn;
        done = 1'b1;
      end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    check_eq("completed", 32'(done), 32'd1);
    check_eq("cycles", 32'(cyc), 32'(exp_cyc));
    check_eq("imem_req_cycles", 32'(ireq), 32'(exp_ireq));
    check_eq("dmem_req_cycles", 32'(dreq), 32'(exp_dreq));
    check_eq("ir_ld_pulses", 32'(irld), (iw >= TO) ? 32'd0 : 32'd1);
    check_eq("pc_ld_pulses", 32'(pcld), exp_trap ? 32'd0 : 32'd1);
    check_eq("rf_wr_pulses", 32'(rfwr), exp_rfwr ? 32'd1 : 32'd0);
    check_eq("mem_wr_pulses", 32'(mwr), (kind == 5 && iw < TO) ? 32'd1 : 32'd0);
    check_eq("trap_seen", 32'(seen_trap), 32'(exp_trap));
    if (kind != 6 && iw < TO) begin
      check_eq("rf_b_sel", 32'(rfb), (kind != 0) ? 32'd1 : 32'd0);
      check_eq("alu_func", 32'(fsel), 32'(exp_func));
      check_eq("alu_bin_sel", 32'(bin), (kind == 1 || kind == 2 || is_mem) ? 32'd1 : 32'd0);
    end
    if (!exp_trap) check_eq("pc_sel", 32'(psel), 32'(exp_take));
    if (exp_rfwr) begin
      check_eq("wr_cycle", 32'(wr_cyc), 32'(exp_cyc));
      check_eq("wr_data_sel", 32'(wsel), (kind == 4) ? 32'd1 : 32'd0);
      check_eq("lui_flag", 32'(luif), (kind == 2) ? 32'd1 : 32'd0);
    end
    if (is_mem && iw < TO) begin
      check_eq("lb_flag", 32'(lbm), (op == O_LB) ? 32'd1 : 32'd0);
      check_eq("sb_flag", 32'(sbm), (op == O_SB) ? 32'd1 : 32'd0);
    end
    if (!exp_trap) model_ret++;
    check_eq("retired", retired, 32'(model_ret));
    if (seen_trap) begin
      check_eq("trap_out", 32'(trap_out), 32'd1);
      check_eq("quiet_in_trap", 32'(busy_at_trap), 32'd0);
      repeat (2) @(negedge clk);
      check_eq("trap_sticky", 32'(state), 32'd7);
      do_reset();
    end
  endtask

  task automatic check_nb_trap(input logic [5:0] op);
    do_reset();
    run_instr(op, 4'h0, 1'b0, 0, 0);
    check_eq("nb_state", 32'(nb_state), 32'd7);
    check_eq("nb_trap", 32'(nb_trap), 32'd1);
    check_eq("nb_retired", nb_retired, 32'd0);
    check_eq("nb_imem_req", 32'(nb_imem_req), 32'd0);
  endtask

  task automatic reset_mid_mem();
    logic reached;
    reached = 1'b0;
    Instr = {O_SW, 22'h0, 4'h0};
    Zero  = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      imem_ready = (state == 3'd0);
      dmem_ready = 1'b0;
      #1;
      if (state == 3'd3) reached = 1'b1;
      else @(negedge clk);
    end
    check_eq("mid_mem_reached", 32'(reached), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("mid_mem_rst_state", 32'(state), 32'd0);
    check_eq("mid_mem_rst_mem_wr", 32'(Mem_WrEn), 32'd0);
    check_eq("mid_mem_rst_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("mid_mem_rst_retired", retired, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    model_ret = 0;
  endtask

  initial begin
    do_reset();
    run_instr(O_R,   4'h0, 1'b0, 0, 0);
    run_instr(O_LW,  4'h0, 1'b0, 0, 2);
    run_instr(O_BEQ, 4'h0, 1'b1, 0, 0);
    run_instr(O_BEQ, 4'h0, 1'b0, 0, 0);
    run_instr(O_BNE, 4'h0, 1'b0, 1, 0);
    run_instr(O_B,   4'h0, 1'b0, 0, 0);
    run_instr(O_SW,  4'h0, 1'b0, 0, 1);
    run_instr(O_LUI, 4'h0, 1'b0, 2, 0);
    run_instr(O_R,   4'h5, 1'b0, TO - 1, 0);
    run_instr(O_LB,  4'h0, 1'b0, 0, TO - 1);
    run_instr(6'b101010, 4'h0, 1'b0, 0, 0);
    run_instr(O_ADDI, 4'h0, 1'b0, 0, 0);
    run_instr(O_R,   4'h0, 1'b0, 10, 0);
    run_instr(O_ANDI, 4'h0, 1'b0, 0, 0);
    run_instr(O_SW,  4'h0, 1'b0, 0, 10);
    check_nb_trap(O_LB);
    check_nb_trap(O_SB);
    do_reset();
    run_instr(O_ORI, 4'h0, 1'b0, 0, 0);
    reset_mid_mem();
    for (int n = 0; n < 150; n++) begin
      run_instr(legal_ops[$urandom_range(0, 12)], 4'($urandom), 1'($urandom),
                $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
